led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for the lab board. It drives N_LEDS outputs in one of four selectable modes: off, blink, shift and bounce. Two raw push-buttons are debounced on-chip: one cycles the mode, the other pauses and resumes. It replaces the fixed 8-LED single-button blink block at the top level, between the board pins and the LED bank.

Parameters:
N_LEDS, 8, number of LED outputs; legal range 2..32.
DIV, 6000000, clock cycles per pattern step (0.5 s at 12 MHz); minimum 2.
DEB_CYCLES, 120000, consecutive stable cycles required to accept a button level (10 ms at 12 MHz); minimum 2.

Ports:
CLK  in  1  system clock; single clock domain.
RST  in  1  reset; synchronous, active-high.
SW_MODE  in  1  raw asynchronous button; each debounced press advances the mode.
SW_RUN  in  1  raw asynchronous button; each debounced press toggles run/pause.
LED  out  N_LEDS  pattern output, registered.
MODE  out  2  current mode, registered: 0=OFF, 1=BLINK, 2=SHIFT, 3=BOUNCE.
RUNNING  out  1  1 = pattern advancing, 0 = paused.

Behaviour:
- Reset (RST=1 at a CLK edge): LED=0, MODE=0, RUNNING=1, prescaler=0, dir=up. Debouncer sync FFs, counters and debounced levels all =0. RST dominates every other event, including mid-sequence.
- Debounce, per button:
  - 2-FF synchroniser.
  - Counter increments while the synced level differs from the debounced level; it clears on any cycle where they match.
  - When the count reaches DEB_CYCLES, the debounced level updates and the counter clears.
  - A 0->1 transition of the debounced level emits a 1-cycle press pulse.
  - Input-to-pulse latency is exactly 2+DEB_CYCLES cycles. Any glitch shorter than DEB_CYCLES is ignored. A release produces no pulse.
- Mode pulse: MODE <= MODE+1 (3 wraps to 0) on the next edge. In the same edge: prescaler clears, dir=up, LED loads the initial pattern.
  - OFF: 0.
  - BLINK: 0.
  - SHIFT: bit0 only.
  - BOUNCE: bit0 only.
- Run pulse: RUNNING <= ~RUNNING on the next edge.
- Mode and run pulses in the same cycle: both take effect. The new mode loads its initial pattern and RUNNING toggles.
- Prescaler: advances only when RUNNING=1 and MODE!=OFF. It counts 0..DIV-1; when it reads DIV-1 it wraps to 0 and issues a step tick. The first step therefore comes DIV cycles after a mode load.
- Paused: prescaler and LED hold their values. A mode press while paused still loads the new initial pattern, and RUNNING stays 0.
- Step behaviour by mode:
  - OFF: LED=0 permanently.
  - BLINK: LED <= ~LED, so all bits toggle together.
  - SHIFT: single hot bit rotates toward the MSB; bit N_LEDS-1 wraps to bit0.
  - BOUNCE: hot bit moves one position in dir. At bit N_LEDS-1 with dir=up, dir flips to down and the bit moves to N_LEDS-2. The symmetric rule applies at bit0. End bits are shown once per sweep, so the period is 2*(N_LEDS-1) steps.
- Invariant: in SHIFT and BOUNCE, LED is always exactly one-hot.

Decomposition:
- Shared package led_pkg holds:
  - mode localparams MODE_OFF, MODE_BLINK, MODE_SHIFT, MODE_BOUNCE;
  - the 2-bit mode width.
- Sub-module btn_debounce (params DEB_CYCLES; ports CLK, RST, BTN_RAW, LEVEL, PRESS) is instantiated twice.
- Prescaler, mode/run registers and pattern logic live in led_pattern_gen.

Test Plan:
All scenarios use N_LEDS=8, DIV=4, DEB_CYCLES=8.
1. RST high 3 cycles, then idle 50 cycles -> LED=0x00, MODE=0, RUNNING=1 throughout.
2. SW_MODE high 5 cycles then low -> no change. SW_MODE high 20 cycles -> MODE=1 exactly 11 cycles after the rising input (10-cycle pulse latency + 1 register stage), one increment only; release adds nothing.
3. MODE=1 -> LED reads 0x00 for 4 cycles, then alternates 0xFF/0x00 every 4 cycles.
4. Press to MODE=2 -> LED=0x01, then 0x02, 0x04 … 0x80, 0x01 at 4-cycle spacing; wrap is checked.
5. Press to MODE=3 -> sequence 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02 (period 14 steps). A SW_RUN press mid-sweep -> RUNNING=0 and LED frozen for 40 cycles. A second SW_RUN press -> resumes from the frozen value in the same direction.
6. Simultaneous SW_MODE and SW_RUN presses in MODE=3 -> MODE=0, LED=0x00, RUNNING toggled. Then RST pulsed mid-BOUNCE -> next edge LED=0x00, MODE=0, RUNNING=1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared mode encoding and helpers for the LED pattern generator.
package led_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SHIFT  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd3;

  // Mode advance wraps BOUNCE back to OFF through natural 2-bit overflow.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    return m + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchroniser, stability counter and a
// registered single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 120000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      // The edge that would bring the count to DEB_CYCLES accepts the new level.
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: off/blink/shift/bounce modes, stepped by a
// prescaler, with debounced mode-cycle and run/pause buttons.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int DIV        = 6000000,
  parameter int DEB_CYCLES = 120000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_MODE,
  input  logic              SW_RUN,
  output logic [N_LEDS-1:0] LED,
  output logic [MODE_W-1:0] MODE,
  output logic              RUNNING
);

  localparam int PW = $clog2(DIV);

  logic              mode_press, run_press;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              run_q, run_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              dir_down_q, dir_down_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              active, step;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (SW_MODE),
    .LEVEL   (),
    .PRESS   (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (SW_RUN),
    .LEVEL   (),
    .PRESS   (run_press)
  );

  assign active = run_q && (mode_q != MODE_OFF);
  assign step   = active && (presc_q == PW'(DIV - 1));

  always_comb begin
    mode_d     = mode_q;
    run_d      = run_q;
    presc_d    = presc_q;
    dir_down_d = dir_down_q;
    led_d      = led_q;

    if (active) presc_d = step ? '0 : presc_q + 1'b1;

    if (step) begin
      case (mode_q)
        MODE_BLINK: led_d = ~led_q;
        MODE_SHIFT: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
        MODE_BOUNCE: begin
          // End bits reverse direction and step inward in the same tick.
          if (!dir_down_q) begin
            if (led_q[N_LEDS-1]) begin
              dir_down_d = 1'b1;
              led_d      = {1'b0, led_q[N_LEDS-1:1]};
            end else begin
              led_d = {led_q[N_LEDS-2:0], 1'b0};
            end
          end else begin
            if (led_q[0]) begin
              dir_down_d = 1'b0;
              led_d      = {led_q[N_LEDS-2:0], 1'b0};
            end else begin
              led_d = {1'b0, led_q[N_LEDS-1:1]};
            end
          end
        end
        default: led_d = '0;
      endcase
    end

    // A mode press overrides any step in the same cycle and restarts the pattern.
    if (mode_press) begin
      mode_d     = next_mode(mode_q);
      presc_d    = '0;
      dir_down_d = 1'b0;
      if (mode_d == MODE_SHIFT || mode_d == MODE_BOUNCE) led_d = N_LEDS'(1);
      else                                               led_d = '0;
    end

    if (run_press) run_d = ~run_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q     <= MODE_OFF;
      run_q      <= 1'b1;
      presc_q    <= '0;
      dir_down_q <= 1'b0;
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      dir_down_q <= dir_down_d;
      led_q      <= led_d;
    end
  end

  assign LED     = led_q;
  assign MODE    = mode_q;
  assign RUNNING = run_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=8, DIV=4, DEB_CYCLES=8.
module tb_led_pattern_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW_MODE = 1'b0;
  logic       SW_RUN = 1'b0;
  logic [7:0] LED;
  logic [1:0] MODE;
  logic       RUNNING;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] shift_exp  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  led_pattern_gen #(.N_LEDS(8), .DIV(4), .DEB_CYCLES(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW_MODE (SW_MODE),
    .SW_RUN  (SW_RUN),
    .LED     (LED),
    .MODE    (MODE),
    .RUNNING (RUNNING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold the chosen buttons until the pulse has been registered (11 edges), then release.
  task automatic press(input logic m, input logic r);
    SW_MODE = m;
    SW_RUN  = r;
    step(11);
    SW_MODE = 1'b0;
    SW_RUN  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // 1. Reset and idle
    step(3);
    check("rst_led", LED, 8'h00);
    check("rst_mode", MODE, 2'd0);
    check("rst_running", RUNNING, 1'b1);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(10);
      check("idle_led", LED, 8'h00);
      check("idle_mode", MODE, 2'd0);
      check("idle_running", RUNNING, 1'b1);
    end

    // 2. Glitch rejected, then a clean press with exact latency
    SW_MODE = 1'b1;
    step(5);
    SW_MODE = 1'b0;
    step(20);
    check("glitch_mode", MODE, 2'd0);

    SW_MODE = 1'b1;
    step(10);
    check("lat10_mode", MODE, 2'd0);
    step(1);
    check("lat11_mode", MODE, 2'd1);
    // 3. Blink timing
    check("blink_load", LED, 8'h00);
    step(3);
    check("blink_hold", LED, 8'h00);
    step(1);
    check("blink_on", LED, 8'hFF);
    step(3);
    check("blink_on_hold", LED, 8'hFF);
    step(1);
    check("blink_off", LED, 8'h00);
    step(1);
    SW_MODE = 1'b0;
    step(3);
    check("blink_on2", LED, 8'hFF);
    step(4);
    check("blink_off2", LED, 8'h00);
    step(30);
    check("release_mode", MODE, 2'd1);

    // 4. Shift with wrap
    press(1'b1, 1'b0);
    check("shift_mode", MODE, 2'd2);
    check("shift_load", LED, 8'h01);
    for (int k = 0; k < 8; k++) begin
      step(4);
      check($sformatf("shift_%0d", k), LED, shift_exp[k]);
    end

    // 5. Bounce, pause, resume
    step(12);
    press(1'b1, 1'b0);
    check("bounce_mode", MODE, 2'd3);
    check("bounce_load", LED, 8'h01);
    for (int k = 0; k < 16; k++) begin
      step(4);
      check($sformatf("bounce_%0d", k), LED, bounce_exp[k]);
    end
    press(1'b0, 1'b1);
    check("pause_running", RUNNING, 1'b0);
    check("pause_led", LED, 8'h10);
    step(40);
    check("frozen_led", LED, 8'h10);
    check("frozen_running", RUNNING, 1'b0);
    press(1'b0, 1'b1);
    check("resume_running", RUNNING, 1'b1);
    check("resume_led", LED, 8'h10);
    step(1);
    check("resume_step1", LED, 8'h20);
    step(4);
    check("resume_step2", LED, 8'h40);
    step(4);
    check("resume_step3", LED, 8'h80);
    step(4);
    check("resume_turn", LED, 8'h40);

    // 6. Simultaneous presses, then reset mid-bounce
    press(1'b1, 1'b1);
    check("both_mode", MODE, 2'd0);
    check("both_led", LED, 8'h00);
    check("both_running", RUNNING, 1'b0);
    step(12);
    press(1'b1, 1'b1);
    check("both2_mode", MODE, 2'd1);
    check("both2_running", RUNNING, 1'b1);
    step(12);
    press(1'b1, 1'b0);
    step(12);
    press(1'b1, 1'b0);
    check("rebounce_mode", MODE, 2'd3);
    check("rebounce_load", LED, 8'h01);
    step(6);
    check("rebounce_step", LED, 8'h02);
    RST = 1'b1;
    step(1);
    check("midrst_led", LED, 8'h00);
    check("midrst_mode", MODE, 2'd0);
    check("midrst_running", RUNNING, 1'b1);
    RST = 1'b0;
    step(20);
    check("post_rst_led", LED, 8'h00);
    check("post_rst_mode", MODE, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
